// File: rtl/crypto_isa_pkg.sv
// rtl/crypto_isa_pkg.sv - shared ISA field layout, opcodes and assembler states
package crypto_isa_pkg;

    localparam int OPC_HI = 15;
    localparam int R1_HI  = 11;
    localparam int R2_HI  = 7;
    localparam int IMM_HI = 3;

    localparam logic [3:0] OP_ADD       = 4'd1;
    localparam logic [3:0] OP_XORENC    = 4'd6;
    localparam logic [3:0] OP_JMP       = 4'd7;
    localparam logic [3:0] OP_MAX_LEGAL = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } asm_state_t;

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - canonicalise instruction fields and pack them into a 16-bit word
module instr_pack
    import crypto_isa_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [3:0]  reg1,
    input  logic [3:0]  reg2,
    input  logic [3:0]  imm,
    output logic [15:0] word,
    output logic        illegal
);

    logic [3:0] r1_c;
    logic [3:0] r2_c;
    logic [3:0] imm_c;

    // Fields an opcode ignores are zeroed so equal programs assemble to equal images.
    always_comb begin
        r1_c  = reg1;
        r2_c  = reg2;
        imm_c = imm;
        case (opcode)
            OP_ADD:    imm_c = 4'd0;
            OP_XORENC: r2_c  = 4'd0;
            OP_JMP: begin
                r1_c = 4'd0;
                r2_c = 4'd0;
            end
            default: ;
        endcase
    end

    always_comb begin
        word                  = 16'd0;
        word[OPC_HI -: 4]     = opcode;
        word[R1_HI  -: 4]     = r1_c;
        word[R2_HI  -: 4]     = r2_c;
        word[IMM_HI -: 4]     = imm_c;
    end

    assign illegal = (opcode > OP_MAX_LEGAL);

endmodule

// File: rtl/instr_assembler.sv
// rtl/instr_assembler.sv - streams instruction fields into consecutive instruction memory words
module instr_assembler
    import crypto_isa_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              fld_valid,
    output logic              fld_ready,
    input  logic [3:0]        opcode,
    input  logic [3:0]        reg1,
    input  logic [3:0]        reg2,
    input  logic [3:0]        imm,
    input  logic              fld_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err_illegal,
    output logic              err_overflow
);

    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    asm_state_t      state;
    logic [ADDR_W:0] addr_q;
    logic [15:0]     word;
    logic            illegal;
    logic            accept;

    instr_pack u_pack (
        .opcode  (opcode),
        .reg1    (reg1),
        .reg2    (reg2),
        .imm     (imm),
        .word    (word),
        .illegal (illegal)
    );

    assign accept = fld_valid && fld_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            addr_q       <= '0;
            fld_ready    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            count        <= '0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            // count trails the visible write strobe by one cycle
            if (mem_we)
                count <= count + ONE;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_LOAD;
                        addr_q       <= {1'b0, base_addr};
                        count        <= '0;
                        err_illegal  <= 1'b0;
                        err_overflow <= 1'b0;
                        fld_ready    <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (illegal || addr_q[ADDR_W] || fld_last) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            fld_ready <= 1'b0;
                        end
                        // address bit ADDR_W set means the memory is already full
                        if (illegal) begin
                            err_illegal <= 1'b1;
                        end else if (addr_q[ADDR_W]) begin
                            err_overflow <= 1'b1;
                        end else begin
                            mem_we    <= 1'b1;
                            mem_addr  <= addr_q[ADDR_W-1:0];
                            mem_wdata <= word;
                            addr_q    <= addr_q + ONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    fld_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
